vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 Parameter V_BP, 33, vertical back porch in lines.
REQ-009 Parameter PIX_DIV, 2, clk_in cycles per pixel, at least 1.
REQ-010 Parameter HS_POL, 0, asserted level of hs.
REQ-011 Parameter VS_POL, 0, asserted level of vs.
REQ-012 Parameter TICK_FRAMES, 1, frames per game_tick, at least 1.
REQ-013 clk_in  input  1  single system clock; all state is clocked on its rising edge.
REQ-014 reset  input  1  asynchronous, active-low reset.
REQ-015 en  input  1  timing enable.
REQ-016 pix_ce  output  1  one-cycle pixel clock enable, asserted every PIX_DIV clk_in cycles.
REQ-017 hs  output  1  horizontal sync.
REQ-018 vs  output  1  vertical sync.
REQ-019 de  output  1  display enable: high while in the active region.
REQ-020 hcount  output  HW  pixel column, where HW = clog2(H_TOTAL).
REQ-021 vcount  output  VW  line number, where VW = clog2(V_TOTAL).
REQ-022 frame_start  output  1  one-cycle pulse when the counters reach (0,0).
REQ-023 game_tick  output  1  one-cycle pulse marking a frame-synchronous game update.

Function
REQ-024 Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-025 Divider: counts 0..PIX_DIV-1 and asserts pix_ce in the cycle it equals PIX_DIV-1; when PIX_DIV=1, pix_ce SHALL be constantly high while en=1.
REQ-026 hcount: advances only in pix_ce cycles, wrapping from H_TOTAL-1 to 0.
REQ-027 vcount: advances only on the hcount wrap, wrapping from V_TOTAL-1 to 0; both counters wrap in the same cycle at (H_TOTAL-1, V_TOTAL-1).
REQ-028 de = (hcount < H_ACTIVE) and (vcount < V_ACTIVE).
REQ-029 hs = HS_POL while H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
REQ-030 vs = VS_POL while V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL.
REQ-031 Output registration: hs, vs and de are registered and consistent with the presented hcount/vcount in the same cycle, with zero relative skew.
REQ-032 frame_start: high for exactly one clk_in cycle, in the cycle hcount/vcount first present (0,0).
REQ-033 Frame counter: 0..TICK_FRAMES-1, incremented at each transition of vcount to V_ACTIVE (start of vertical blanking).
REQ-034 game_tick: pulses for one clk_in cycle at that transition when the frame counter equals TICK_FRAMES-1, then the counter returns to 0.
REQ-035 en=0: divider, hcount, vcount and frame counter are cleared and held; de=0; hs/vs inactive; pix_ce, frame_start and game_tick low.
REQ-036 en rising: timing restarts at (0,0), with the first pix_ce PIX_DIV cycles later; frame_start fires at that first (0,0) presentation.
REQ-037 en falling mid-frame: the line is abandoned immediately and no partial game_tick is emitted.

Reset
REQ-038 While reset=0, asynchronously: divider=0, hcount=0, vcount=0, frame counter=0, pix_ce=0, de=0, hs=~HS_POL, vs=~VS_POL, frame_start=0, game_tick=0.
REQ-039 After reset deassertion, behaviour is identical to an en rising edge (REQ-036).

Structure
REQ-040 Shared package vga_pkg: default 640x480@60 timing constants, the clog2 width function, and the H_TOTAL/V_TOTAL derivation.
REQ-041 One sub-module, clk_en_div (parametrised by PIX_DIV), SHALL generate pix_ce; all other logic resides in vga_timing_gen.

Verification
REQ-042 Bench parameters: H 8/2/3/1 (H_TOTAL=14), V 4/1/2/1 (V_TOTAL=8), PIX_DIV=2, TICK_FRAMES=3, HS_POL=VS_POL=0.
REQ-043 Free run after reset: pix_ce every 2nd cycle; hs low exactly for hcount 10..12; de high for hcount 0..7 when vcount 0..3; frame period = 224 clk_in cycles.
REQ-044 Line/frame wrap: at (13,7) the next pix_ce yields (0,0) with frame_start=1 for one cycle.
REQ-045 Game tick: over 9 frames, exactly 3 game_tick pulses, each coinciding with vcount becoming 4, on frames 3, 6 and 9.
REQ-046 en dropped at (5,2) for 10 cycles then raised: outputs held idle, restart at (0,0), frame_start fires and no game_tick is emitted for the aborted frame.
REQ-047 Async reset asserted mid-sync (hs low): hs returns high and the counters read 0 before the next clk_in edge.
REQ-048 With PIX_DIV=1: pix_ce constantly high and frame period = 112 cycles.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480@60), FSM state type and width/total helpers.
package vga_pkg;

    localparam int unsigned VGA_H_ACTIVE    = 640;
    localparam int unsigned VGA_H_FP        = 16;
    localparam int unsigned VGA_H_SYNC      = 96;
    localparam int unsigned VGA_H_BP        = 48;
    localparam int unsigned VGA_V_ACTIVE    = 480;
    localparam int unsigned VGA_V_FP        = 10;
    localparam int unsigned VGA_V_SYNC      = 2;
    localparam int unsigned VGA_V_BP        = 33;
    localparam int unsigned VGA_PIX_DIV     = 2;
    localparam int unsigned VGA_TICK_FRAMES = 1;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } vga_state_t;

    // Bits needed to hold 0..value-1; never narrower than one bit.
    function automatic int unsigned vga_clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) w = i + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int unsigned vga_total(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/clk_en_div.sv
// Pixel clock-enable divider: one-cycle pix_ce every PIX_DIV clk_in cycles while en is high.
module clk_en_div
    import vga_pkg::*;
#(
    parameter int unsigned PIX_DIV = VGA_PIX_DIV
) (
    input  logic clk_in,
    input  logic reset,
    input  logic en,
    output logic pix_ce
);

    localparam int unsigned   DW       = vga_clog2(PIX_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

    logic [DW-1:0] div_q, div_d;
    logic          ce_q, ce_d;

    always_comb begin
        div_d = '0;
        ce_d  = 1'b0;
        if (en) begin
            ce_d  = (div_q == DIV_LAST);
            div_d = ce_d ? '0 : div_q + DW'(1);
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            ce_q  <= ce_d;
        end
    end

    assign pix_ce = ce_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, registered syncs and display enable,
// frame-start pulse and a frame-synchronous game tick every TICK_FRAMES frames.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
    parameter int unsigned H_FP        = VGA_H_FP,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_BP        = VGA_H_BP,
    parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
    parameter int unsigned V_FP        = VGA_V_FP,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_BP        = VGA_V_BP,
    parameter int unsigned PIX_DIV     = VGA_PIX_DIV,
    parameter bit          HS_POL      = 1'b0,
    parameter bit          VS_POL      = 1'b0,
    parameter int unsigned TICK_FRAMES = VGA_TICK_FRAMES,
    localparam int unsigned H_TOTAL    = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int unsigned V_TOTAL    = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int unsigned HW         = vga_clog2(H_TOTAL),
    localparam int unsigned VW         = vga_clog2(V_TOTAL)
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          en,
    output logic          pix_ce,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          frame_start,
    output logic          game_tick
);

    localparam int unsigned   FW       = vga_clog2(TICK_FRAMES);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_BLANK  = VW'(V_ACTIVE);
    localparam logic [FW-1:0] F_LAST   = FW'(TICK_FRAMES - 1);
    localparam int unsigned   HS_START = H_ACTIVE + H_FP;
    localparam int unsigned   HS_END   = HS_START + H_SYNC;
    localparam int unsigned   VS_START = V_ACTIVE + V_FP;
    localparam int unsigned   VS_END   = VS_START + V_SYNC;

    vga_state_t    state_q, state_d;
    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          de_q, de_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          fs_q, fs_d;
    logic          gt_q, gt_d;

    clk_en_div #(
        .PIX_DIV (PIX_DIV)
    ) u_div (
        .clk_in (clk_in),
        .reset  (reset),
        .en     (en),
        .pix_ce (pix_ce)
    );

    // Sync/enable outputs are decoded from the next counter values so that,
    // once registered, they line up with hcount/vcount in the same cycle.
    always_comb begin
        state_d  = en ? ST_RUN : ST_IDLE;
        hcount_d = '0;
        vcount_d = '0;
        fcnt_d   = '0;
        de_d     = 1'b0;
        hs_d     = ~HS_POL;
        vs_d     = ~VS_POL;
        fs_d     = 1'b0;
        gt_d     = 1'b0;
        if (en) begin
            hcount_d = hcount_q;
            vcount_d = vcount_q;
            fcnt_d   = fcnt_q;
            if (pix_ce) begin
                if (hcount_q == H_LAST) begin
                    hcount_d = '0;
                    vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + VW'(1);
                end else begin
                    hcount_d = hcount_q + HW'(1);
                end
            end
            de_d = (32'(hcount_d) < H_ACTIVE) && (32'(vcount_d) < V_ACTIVE);
            hs_d = ((32'(hcount_d) >= HS_START) && (32'(hcount_d) < HS_END)) ? HS_POL : ~HS_POL;
            vs_d = ((32'(vcount_d) >= VS_START) && (32'(vcount_d) < VS_END)) ? VS_POL : ~VS_POL;
            // Origin is flagged on the first running cycle and on every true wrap.
            fs_d = (hcount_d == '0) && (vcount_d == '0) &&
                   ((state_q == ST_IDLE) || (hcount_q != '0) || (vcount_q != '0));
            if ((vcount_d == V_BLANK) && (vcount_q != V_BLANK)) begin
                if (fcnt_q == F_LAST) begin
                    fcnt_d = '0;
                    gt_d   = 1'b1;
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            hcount_q <= '0;
            vcount_q <= '0;
            fcnt_q   <= '0;
            de_q     <= 1'b0;
            hs_q     <= ~HS_POL;
            vs_q     <= ~VS_POL;
            fs_q     <= 1'b0;
            gt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            fcnt_q   <= fcnt_d;
            de_q     <= de_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            fs_q     <= fs_d;
            gt_q     <= gt_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign de          = de_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign frame_start = fs_q;
    assign game_tick   = gt_q;

endmodule
